// File: rtl/text_console_ctrl_pkg.sv
// Shared types and constants for the text console VRAM sequencer.
package console_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_SCROLL_RD,
    ST_SCROLL_WR,
    ST_FILL,
    ST_CLEAR
  } state_e;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_FF    = 8'h0C;

  localparam int DEF_COLS = 64;
  localparam int DEF_ROWS = 30;

  localparam int ROW_W  = 5;
  localparam int COL_W  = 6;
  localparam int ADDR_W = ROW_W + COL_W;

  function automatic logic [ADDR_W-1:0] pack_addr(input logic [ROW_W-1:0] r,
                                                  input logic [COL_W-1:0] c);
    return {r, c};
  endfunction

endpackage

// File: rtl/text_console_ctrl_if.sv
// CPU character handshake plus the VRAM port owned by the console controller.
interface text_console_ctrl_if;
  import console_pkg::*;

  logic [7:0]        cpu_char;
  logic              cpu_valid;
  logic              cpu_ready;
  logic [ADDR_W-1:0] vram_addr;
  logic [7:0]        vram_wdata;
  logic              vram_we;
  logic [7:0]        vram_rdata;

  modport master (
    input  cpu_char, cpu_valid, vram_rdata,
    output cpu_ready, vram_addr, vram_wdata, vram_we
  );

  modport slave (
    output cpu_char, cpu_valid, vram_rdata,
    input  cpu_ready, vram_addr, vram_wdata, vram_we
  );
endinterface

// File: rtl/text_console_ctrl_rr_arb2.sv
// Two-requester round-robin; the side not granted last time wins a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  // last_q = 1 means requester 1 took the most recent transfer
  logic last_q, last_d;

  always_comb begin
    gnt_o = req_i;
    if (req_i[0] && req_i[1]) gnt_o = last_q ? 2'b01 : 2'b10;
    last_d = last_q;
    if (accept_i && (gnt_o != 2'b00)) last_d = gnt_o[1];
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/text_console_ctrl.sv
// Character sequencer for the text VRAM: cursor, control codes, clear and
// scroll-by-row-copy, fed from a one-entry keyboard buffer and a CPU port.
module text_console_ctrl
  import console_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       kb_char_i,
  input  logic             kb_valid_i,
  text_console_ctrl_if.master bus,
  output logic [ROW_W-1:0] cur_row_o,
  output logic [COL_W-1:0] cur_col_o,
  output logic             busy_o,
  output logic             kb_overflow_o
);

  localparam logic [COL_W-1:0] COL_MAX     = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_MAX     = ROW_W'(ROWS - 1);
  localparam logic [ROW_W-1:0] SCR_ROW_MAX = ROW_W'(ROWS - 2);

  state_e           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] sr_q, sr_d;
  logic [COL_W-1:0] sc_q, sc_d;
  logic [7:0]       char_q, char_d;
  logic             kb_pend_q, kb_pend_d;
  logic [7:0]       kb_char_q, kb_char_d;
  logic             kb_ovf_q, kb_ovf_d;

  logic [1:0]        req, gnt;
  logic              accept, consume, adv_row;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        wdata;

  // index 0 = CPU, index 1 = keyboard
  assign req     = {kb_pend_q, bus.cpu_valid} & {2{state_q == ST_IDLE}};
  assign accept  = |gnt;
  assign consume = accept & gnt[1];

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req),
    .accept_i (accept),
    .gnt_o    (gnt)
  );

  always_comb begin
    kb_pend_d = kb_pend_q;
    kb_char_d = kb_char_q;
    kb_ovf_d  = kb_ovf_q;
    if (consume) kb_pend_d = 1'b0;
    if (kb_valid_i) begin
      if (kb_pend_q && !consume) begin
        kb_ovf_d = 1'b1;
      end else begin
        kb_pend_d = 1'b1;
        kb_char_d = kb_char_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    sr_d    = sr_q;
    sc_d    = sc_q;
    char_d  = char_q;
    we      = 1'b0;
    addr    = '0;
    wdata   = CH_SPACE;
    adv_row = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          char_d  = gnt[1] ? kb_char_q : bus.cpu_char;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_IDLE;
        if (char_q >= 8'h20 && char_q <= 8'h7E) begin
          we    = 1'b1;
          addr  = pack_addr(row_q, col_q);
          wdata = char_q;
          if (col_q == COL_MAX) begin
            col_d   = '0;
            adv_row = 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end else if (char_q == CH_LF || char_q == CH_CR) begin
          col_d   = '0;
          adv_row = 1'b1;
        end else if (char_q == CH_BS) begin
          if (col_q != '0) begin
            col_d = col_q - 1'b1;
            we    = 1'b1;
            addr  = pack_addr(row_q, col_q - 1'b1);
          end else if (row_q != '0) begin
            row_d = row_q - 1'b1;
            col_d = COL_MAX;
            we    = 1'b1;
            addr  = pack_addr(row_q - 1'b1, COL_MAX);
          end
        end else if (char_q == CH_FF) begin
          state_d = ST_CLEAR;
          sr_d    = '0;
          sc_d    = '0;
        end
        // bottom row: cursor stays put and the screen moves up instead
        if (adv_row) begin
          if (row_q != ROW_MAX) begin
            row_d = row_q + 1'b1;
          end else begin
            state_d = ST_SCROLL_RD;
            sr_d    = '0;
            sc_d    = '0;
          end
        end
      end
      ST_SCROLL_RD: begin
        addr    = pack_addr(sr_q + 1'b1, sc_q);
        state_d = ST_SCROLL_WR;
      end
      ST_SCROLL_WR: begin
        we      = 1'b1;
        addr    = pack_addr(sr_q, sc_q);
        wdata   = bus.vram_rdata;
        state_d = ST_SCROLL_RD;
        if (sc_q == COL_MAX) begin
          sc_d = '0;
          if (sr_q == SCR_ROW_MAX) state_d = ST_FILL;
          else                     sr_d    = sr_q + 1'b1;
        end else begin
          sc_d = sc_q + 1'b1;
        end
      end
      ST_FILL: begin
        we   = 1'b1;
        addr = pack_addr(ROW_MAX, sc_q);
        if (sc_q == COL_MAX) begin
          sc_d    = '0;
          state_d = ST_IDLE;
        end else begin
          sc_d = sc_q + 1'b1;
        end
      end
      ST_CLEAR: begin
        we   = 1'b1;
        addr = pack_addr(sr_q, sc_q);
        if (sc_q == COL_MAX) begin
          sc_d = '0;
          if (sr_q == ROW_MAX) begin
            sr_d    = '0;
            row_d   = '0;
            col_d   = '0;
            state_d = ST_IDLE;
          end else begin
            sr_d = sr_q + 1'b1;
          end
        end else begin
          sc_d = sc_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      row_q     <= '0;
      col_q     <= '0;
      sr_q      <= '0;
      sc_q      <= '0;
      char_q    <= '0;
      kb_pend_q <= 1'b0;
      kb_char_q <= '0;
      kb_ovf_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      sr_q      <= sr_d;
      sc_q      <= sc_d;
      char_q    <= char_d;
      kb_pend_q <= kb_pend_d;
      kb_char_q <= kb_char_d;
      kb_ovf_q  <= kb_ovf_d;
    end
  end

  // rst gates the port combinationally so an abandoned scroll/clear stops at once
  assign bus.vram_we    = we & ~rst;
  assign bus.vram_addr  = rst ? '0 : addr;
  assign bus.vram_wdata = wdata;
  assign bus.cpu_ready  = gnt[0] & ~rst;
  assign busy_o         = rst | (state_q != ST_IDLE);
  assign cur_row_o      = row_q;
  assign cur_col_o      = col_q;
  assign kb_overflow_o  = kb_ovf_q;

endmodule

// File: tb/tb_text_console_ctrl.sv
// Directed bench for text_console_ctrl with a behavioural synchronous VRAM.
module tb_text_console_ctrl;
  import console_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] kb_char = 8'h00;
  logic       kb_valid = 1'b0;
  logic [4:0] cur_row;
  logic [5:0] cur_col;
  logic       busy, kb_overflow;

  text_console_ctrl_if bus_if ();

  text_console_ctrl #(.COLS(64), .ROWS(30)) dut (
    .clk           (clk),
    .rst           (rst),
    .kb_char_i     (kb_char),
    .kb_valid_i    (kb_valid),
    .bus           (bus_if),
    .cur_row_o     (cur_row),
    .cur_col_o     (cur_col),
    .busy_o        (busy),
    .kb_overflow_o (kb_overflow)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:2047];
  logic        bd_we = 1'b0;
  logic [10:0] bd_addr = '0;
  logic [7:0]  bd_data = '0;
  int          wr_cnt = 0, wr_nonsp = 0, we_in_rst = 0;

  always @(posedge clk) begin
    bus_if.vram_rdata <= mem[bus_if.vram_addr];
    if (bus_if.vram_we) begin
      mem[bus_if.vram_addr] <= bus_if.vram_wdata;
      wr_cnt++;
      if (bus_if.vram_wdata != 8'h20) wr_nonsp++;
    end else if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end
    if (rst && bus_if.vram_we) we_in_rst++;
  end

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk({nm, " idle timeout"}, 32'd1, 32'd0);
  endtask

  // returns at the negedge of the EXEC cycle for this character
  task automatic cpu_send(input logic [7:0] ch);
    int n = 0;
    bus_if.cpu_char  = ch;
    bus_if.cpu_valid = 1'b1;
    #1;
    while (!bus_if.cpu_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!bus_if.cpu_ready) begin
      chk("cpu accept timeout", 32'd0, 32'd1);
      bus_if.cpu_valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      bus_if.cpu_valid = 1'b0;
    end
  endtask

  task automatic kb_strobe(input logic [7:0] ch);
    kb_char  = ch;
    kb_valid = 1'b1;
    @(negedge clk);
    kb_valid = 1'b0;
  endtask

  task automatic chk_cursor(input string nm, input int r, input int c);
    chk({nm, " row"}, 32'(cur_row), 32'(r));
    chk({nm, " col"}, 32'(cur_col), 32'(c));
  endtask

  typedef struct {
    logic [7:0]  ch;
    logic        we;
    logic [10:0] addr;
    logic [7:0]  data;
    logic [4:0]  row;
    logic [5:0]  col;
  } vec_t;

  vec_t vec [14];

  initial begin
    int w0, n0, cyc, errs;

    // starts at cursor (0,5)
    vec[0]  = '{8'h0D, 1'b0, 11'h000, 8'h00, 5'd1, 6'd0};
    vec[1]  = '{8'h78, 1'b1, 11'h040, 8'h78, 5'd1, 6'd1};
    vec[2]  = '{8'h08, 1'b1, 11'h040, 8'h20, 5'd1, 6'd0};
    vec[3]  = '{8'h08, 1'b1, 11'h03F, 8'h20, 5'd0, 6'd63};
    vec[4]  = '{8'h5A, 1'b1, 11'h03F, 8'h5A, 5'd1, 6'd0};
    vec[5]  = '{8'h01, 1'b0, 11'h000, 8'h00, 5'd1, 6'd0};
    vec[6]  = '{8'h7F, 1'b0, 11'h000, 8'h00, 5'd1, 6'd0};
    vec[7]  = '{8'h7E, 1'b1, 11'h040, 8'h7E, 5'd1, 6'd1};
    vec[8]  = '{8'h20, 1'b1, 11'h041, 8'h20, 5'd1, 6'd2};
    vec[9]  = '{8'h0A, 1'b0, 11'h000, 8'h00, 5'd2, 6'd0};
    vec[10] = '{8'h0A, 1'b0, 11'h000, 8'h00, 5'd3, 6'd0};
    vec[11] = '{8'h08, 1'b1, 11'h0BF, 8'h20, 5'd2, 6'd63};
    vec[12] = '{8'h71, 1'b1, 11'h0BF, 8'h71, 5'd3, 6'd0};
    vec[13] = '{8'h1F, 1'b0, 11'h000, 8'h00, 5'd3, 6'd0};

    bus_if.cpu_char  = 8'h00;
    bus_if.cpu_valid = 1'b0;

    // reset state and VRAM pre-fill
    tick(2);
    chk("rst we", 32'(bus_if.vram_we), 32'd0);
    chk("rst addr", 32'(bus_if.vram_addr), 32'd0);
    chk("rst busy", 32'(busy), 32'd1);
    chk("rst cpu_ready", 32'(bus_if.cpu_ready), 32'd0);
    chk("rst overflow", 32'(kb_overflow), 32'd0);
    chk_cursor("rst", 0, 0);
    for (int a = 0; a < 2048; a++) begin
      bd_addr = 11'(a);
      bd_data = 8'h41;
      bd_we   = 1'b1;
      @(negedge clk);
    end
    bd_we = 1'b0;

    // clear after reset release
    w0 = wr_cnt;
    n0 = wr_nonsp;
    rst = 1'b0;
    cyc = 0;
    while (busy && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    chk("clear cycles", 32'(cyc), 32'd1920);
    chk("clear writes", 32'(wr_cnt - w0), 32'd1920);
    chk("clear non-space writes", 32'(wr_nonsp - n0), 32'd0);
    errs = 0;
    for (int a = 0; a < 1920; a++) if (mem[a] !== 8'h20) errs++;
    chk("clear coverage", 32'(errs), 32'd0);
    errs = 0;
    for (int a = 1920; a < 2048; a++) if (mem[a] !== 8'h41) errs++;
    chk("clear out-of-range", 32'(errs), 32'd0);
    chk_cursor("after clear", 0, 0);

    // keyboard characters
    kb_strobe(8'h48);
    tick(3);
    kb_strobe(8'h69);
    tick(3);
    wait_idle("kb");
    chk("kb H", 32'(mem[0]), 32'h48);
    chk("kb i", 32'(mem[1]), 32'h69);
    chk_cursor("kb", 0, 2);

    // simultaneous requests: CPU wins first tie, keyboard the next
    kb_strobe(8'h42);
    bus_if.cpu_char  = 8'h41;
    bus_if.cpu_valid = 1'b1;
    #1;
    chk("tie1 cpu_ready", 32'(bus_if.cpu_ready), 32'd1);
    @(negedge clk);
    chk("tie1 we", 32'(bus_if.vram_we), 32'd1);
    chk("tie1 addr", 32'(bus_if.vram_addr), 32'h002);
    chk("tie1 data", 32'(bus_if.vram_wdata), 32'h41);
    bus_if.cpu_char = 8'h43;
    @(negedge clk);
    chk("tie2 cpu_ready", 32'(bus_if.cpu_ready), 32'd0);
    @(negedge clk);
    chk("tie2 addr", 32'(bus_if.vram_addr), 32'h003);
    chk("tie2 data", 32'(bus_if.vram_wdata), 32'h42);
    @(negedge clk);
    chk("tie3 cpu_ready", 32'(bus_if.cpu_ready), 32'd1);
    @(negedge clk);
    bus_if.cpu_valid = 1'b0;
    chk("tie3 addr", 32'(bus_if.vram_addr), 32'h004);
    chk("tie3 data", 32'(bus_if.vram_wdata), 32'h43);
    @(negedge clk);
    chk_cursor("tie", 0, 5);

    // table of single characters
    for (int i = 0; i < 14; i++) begin
      cpu_send(vec[i].ch);
      chk($sformatf("v%0d we", i), 32'(bus_if.vram_we), 32'(vec[i].we));
      if (vec[i].we) begin
        chk($sformatf("v%0d addr", i), 32'(bus_if.vram_addr), 32'(vec[i].addr));
        chk($sformatf("v%0d data", i), 32'(bus_if.vram_wdata), 32'(vec[i].data));
      end
      @(negedge clk);
      chk($sformatf("v%0d busy", i), 32'(busy), 32'd0);
      chk_cursor($sformatf("v%0d", i), int'(vec[i].row), int'(vec[i].col));
    end

    // overflow during form-feed clear, then backspace at (0,1) and (0,0)
    cpu_send(8'h0C);
    chk("ff we", 32'(bus_if.vram_we), 32'd0);
    kb_strobe(8'h51);
    tick(3);
    kb_strobe(8'h52);
    chk("ovf flag", 32'(kb_overflow), 32'd1);
    chk("ovf busy", 32'(busy), 32'd1);
    wait_idle("ff clear");
    tick(2);
    chk("ovf Q kept", 32'(mem[0]), 32'h51);
    chk("ovf R dropped", 32'(mem[1]), 32'h20);
    chk("ff cleared", 32'(mem[11'h040]), 32'h20);
    chk_cursor("ovf", 0, 1);
    cpu_send(8'h08);
    chk("bs01 we", 32'(bus_if.vram_we), 32'd1);
    chk("bs01 addr", 32'(bus_if.vram_addr), 32'h000);
    chk("bs01 data", 32'(bus_if.vram_wdata), 32'h20);
    @(negedge clk);
    chk_cursor("bs01", 0, 0);
    w0 = wr_cnt;
    cpu_send(8'h08);
    chk("bs00 we", 32'(bus_if.vram_we), 32'd0);
    @(negedge clk);
    chk("bs00 writes", 32'(wr_cnt - w0), 32'd0);
    chk_cursor("bs00", 0, 0);

    // scroll from (29,5)
    for (int i = 0; i < 29; i++) cpu_send(8'h0A);
    for (int i = 0; i < 5; i++) cpu_send(8'h20);
    @(negedge clk);
    chk_cursor("pre-scroll", 29, 5);
    for (int a = 0; a < 1920; a++) begin
      bd_addr = 11'(a);
      bd_data = 8'(a / 64);
      bd_we   = 1'b1;
      @(negedge clk);
    end
    bd_we = 1'b0;
    w0 = wr_cnt;
    cpu_send(8'h0A);
    chk("scroll exec we", 32'(bus_if.vram_we), 32'd0);
    cyc = 0;
    while (busy && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    chk("scroll cycles", 32'(cyc - 1), 32'd3776);
    chk("scroll writes", 32'(wr_cnt - w0), 32'd1920);
    errs = 0;
    for (int r = 0; r < 29; r++)
      for (int c = 0; c < 64; c++)
        if (mem[r * 64 + c] !== 8'(r + 1)) errs++;
    chk("scroll rows", 32'(errs), 32'd0);
    errs = 0;
    for (int c = 0; c < 64; c++) if (mem[29 * 64 + c] !== 8'h20) errs++;
    chk("scroll fill", 32'(errs), 32'd0);
    chk_cursor("scroll", 29, 0);

    // reset in the middle of a clear
    cpu_send(8'h0C);
    tick(100);
    rst = 1'b1;
    w0 = wr_cnt;
    #1;
    chk("midrst we", 32'(bus_if.vram_we), 32'd0);
    chk("midrst addr", 32'(bus_if.vram_addr), 32'd0);
    chk("midrst busy", 32'(busy), 32'd1);
    tick(5);
    chk("midrst writes", 32'(wr_cnt - w0), 32'd0);
    chk("midrst overflow", 32'(kb_overflow), 32'd0);
    chk_cursor("midrst", 0, 0);
    rst = 1'b0;
    wait_idle("post-rst clear");
    chk("post-rst busy", 32'(busy), 32'd0);
    chk("we during rst", 32'(we_in_rst), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/text_console_ctrl.md
# text_console_ctrl

Sequencer and arbiter for the character video RAM (VRAM) that the VGA text scanner reads. It accepts characters from two requesters, the PS/2 keyboard decoder and a CPU MMIO port, and keeps a cursor. It turns each character into VRAM writes: place, newline, backspace, clear, and scroll-up by row copy. It owns the VRAM write port; the top level adds the VRAM base address.

## Interface
- `COLS`, 64: characters per row, ≤ 64.
- `ROWS`, 30: visible rows, ≤ 32.
- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `kb_char` in 8: ASCII code from the keyboard decoder.
- `kb_valid` in 1: one-cycle strobe; `kb_char` is valid in that cycle.
- `cpu_char` in 8: ASCII code from the CPU store.
- `cpu_valid` in 1: held high until accepted.
- `cpu_ready` out 1: CPU character is accepted in any cycle where `cpu_valid && cpu_ready`.
- `vram_addr` out 11: VRAM address `{row[4:0], col[5:0]}`.
- `vram_wdata` out 8: write data.
- `vram_we` out 1: write enable.
- `vram_rdata` in 8: read data; arrives 1 cycle after the address (synchronous RAM).
- `cur_row` out 5 and `cur_col` out 6: cursor position.
- `busy` out 1: high in any state other than IDLE.
- `kb_overflow` out 1: sticky flag; cleared only by `rst`.

## Operation
- **Keyboard buffer.** A one-entry holding register, `kb_pend`, captures each `kb_valid` strobe.
  - A strobe arriving while `kb_pend` is set is dropped and sets `kb_overflow`.
  - A strobe arriving in the same cycle the pending entry is consumed is captured.
- **Arbitration.** Done only in IDLE, between `kb_pend` and `cpu_valid`, by round-robin.
  - The requester not granted last time wins a tie.
  - After reset, the CPU wins the first tie.
  - `cpu_ready` is high only in IDLE, and only when the CPU is granted.
- **States:** IDLE, EXEC, SCROLL_RD, SCROLL_WR, FILL, CLEAR.
- **EXEC** takes one cycle per accepted character:
  - Printable 0x20–0x7E: write the character at the cursor; `col+1`. If `col == COLS-1`, go to col 0 and advance the row.
  - 0x0A or 0x0D: col 0; advance the row. No write.
  - 0x08 (backspace):
    - col > 0: col−1, write 0x20 at the new position.
    - col == 0 and row > 0: go to (row−1, COLS−1) and write 0x20 there.
    - At (0,0): no action.
  - 0x0C: go to CLEAR.
  - Any other code: consumed, nothing else happens.
- **Row advance.** If row < ROWS−1, row+1 and go to IDLE. Otherwise the row stays at ROWS−1 and the FSM goes to SCROLL_RD.
- **Scroll.** For each destination cell (r, c), r = 0..ROWS−2, c = 0..COLS−1, in row-major order:
  - SCROLL_RD drives the address (r+1, c).
  - SCROLL_WR writes `vram_rdata` to (r, c).
  - The scroll then goes to FILL.
- **FILL** writes 0x20 to (ROWS−1, 0..COLS−1), one cell per cycle, then goes to IDLE.
- **CLEAR** writes 0x20 to every cell (0,0)..(ROWS−1, COLS−1), one per cycle. The cursor becomes (0,0), then the FSM goes to IDLE.
- **Reset.** While `rst` is high:
  - State is CLEAR with the scan counter at 0; `vram_we=0`; `vram_addr=0`; cursor (0,0); `cpu_ready=0`; `kb_pend=0`; `kb_overflow=0`; `busy=1`.
  - On the first cycle after release, CLEAR starts writing.
  - Asserting `rst` mid-scroll or mid-clear abandons that operation immediately; no further writes occur.

## Timing
- **Character accept, cycle T:**
  - T+1 is EXEC: `vram_we=1` for exactly one cycle, carrying the address and data.
  - Cursor outputs update at the T+1→T+2 edge.
  - IDLE is re-entered at T+2.
  - Peak throughput is 1 character per 2 cycles.
- **Keyboard latency.** A strobe at T is visible as `kb_pend` at T+1 and can be granted at T+1.
- **Scroll** costs 2·(ROWS−1)·COLS + COLS cycles (3776 at the defaults).
- **Clear** costs ROWS·COLS cycles (1920 at the defaults).
- **Write enable** is never asserted in IDLE, SCROLL_RD, or during reset.
- **Address arithmetic.** Row/col counters wrap only at the limits above. Addresses always fit `{5b, 6b}`; col is never ≥ COLS.

## Structure
- **Package `console_pkg`:**
  - State enum.
  - ASCII constants: `CH_SPACE`=0x20, `CH_BS`=0x08, `CH_LF`=0x0A, `CH_CR`=0x0D, `CH_FF`=0x0C.
  - Default `COLS` and `ROWS`.
  - Address-packing function `{row, col}`.
- **Sub-module `rr_arb2`:**
  - Two-request round-robin with a registered last-grant bit.
  - Grant is combinational from the requests plus that bit.
  - Advances only on an accepted transfer.

## Test plan
- **Reset then clear.** Release `rst` with the VRAM pre-filled with 0x41.
  - Exactly 1920 writes of 0x20 covering addresses row 0–29, col 0–63.
  - `busy` then falls and the cursor is (0,0).
- **Keyboard characters.** Send `kb_valid` with 'H' then 'i' at least 2 cycles apart.
  - VRAM[0x000]=0x48 and VRAM[0x001]=0x69; cursor (0,2).
- **Simultaneous requests.** `cpu_valid` with 'A' and a keyboard strobe 'B' in the same IDLE cycle after reset.
  - 'A' is written first, then 'B'.
  - A second simultaneous request then grants the keyboard first.
- **Overflow.** Two `kb_valid` strobes while `busy` is high in CLEAR.
  - The first is buffered, the second is dropped, and `kb_overflow=1`.
- **Scroll.** Fill rows 0–29, with each row holding its row number, then send 0x0A at (29,5).
  - Row r holds r+1 for r=0..28; row 29 is all 0x20.
  - Cursor (29,0); completes in 3776 cycles.
- **Backspace.** Backspace at (3,0) → cursor (2,63) and VRAM[{2,63}]=0x20. Backspace at (0,0) → no write.
